// File: rtl/uart_tx_core.sv
// uart_tx_core: 8-bit UART transmitter, LSB first, optional parity, 1 or 2 stop bits.
// A byte is taken on en_i while ready_o is high; tx_o is driven from a register.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CTR_WID      = 10,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       en_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic [7:0] dbg_txcnt_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [CTR_WID-1:0] LAST_CNT  = CTR_WID'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         LAST_STOP = 3'(STOP_BITS - 1);

    state_t             state_q, state_d;
    logic [CTR_WID-1:0] cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         sh_q, sh_d;
    logic               par_q, par_d;
    logic               tx_d;
    logic [7:0]         txcnt_d;
    logic               bit_end;

    assign bit_end = (cnt_q == LAST_CNT);
    assign ready_o = (state_q == S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            par_q       <= 1'b0;
            tx_o        <= 1'b1;
            dbg_txcnt_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            par_q       <= par_d;
            tx_o        <= tx_d;
            dbg_txcnt_o <= txcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        txcnt_d = dbg_txcnt_o;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    sh_d    = data_i;
                    par_d   = (PARITY == 1) ? ~^data_i : ^data_i;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // idx_q is reused to count stop bits
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        txcnt_d = dbg_txcnt_o + 8'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // line level follows the state being entered so tx_o lands on the same edge
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four parameter sets, queued expected frames,
// a monitor that checks every cycle of each frame against the queue.
module tb_uart_tx_core;
    typedef struct packed {
        logic [11:0] bits;
        int          nb;
        int          cpb;
        int          gap;
        int          cut;
        logic [7:0]  cnt;
        logic [1:0]  inst;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic [3:0] rdy;
    logic [3:0] tx;
    logic [7:0] din [4];
    logic [7:0] cnt [4];

    int cpb_c [4] = '{4, 4, 4, 2};
    int par_c [4] = '{0, 2, 1, 0};
    int stp_c [4] = '{1, 2, 2, 1};

    logic [7:0] exp_cnt [4];
    frame_t     q[$];
    int         total = 0;
    int         bad = 0;
    bit         mon_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_core #(.CLKS_PER_BIT(4), .CTR_WID(3), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .rst_i(rst), .data_i(din[0]), .en_i(en[0]),
        .ready_o(rdy[0]), .tx_o(tx[0]), .dbg_txcnt_o(cnt[0])
    );
    uart_tx_core #(.CLKS_PER_BIT(4), .CTR_WID(3), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk_i(clk), .rst_i(rst), .data_i(din[1]), .en_i(en[1]),
        .ready_o(rdy[1]), .tx_o(tx[1]), .dbg_txcnt_o(cnt[1])
    );
    uart_tx_core #(.CLKS_PER_BIT(4), .CTR_WID(3), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk_i(clk), .rst_i(rst), .data_i(din[2]), .en_i(en[2]),
        .ready_o(rdy[2]), .tx_o(tx[2]), .dbg_txcnt_o(cnt[2])
    );
    uart_tx_core #(.CLKS_PER_BIT(2), .CTR_WID(2), .PARITY(0), .STOP_BITS(1)) u3 (
        .clk_i(clk), .rst_i(rst), .data_i(din[3]), .en_i(en[3]),
        .ready_o(rdy[3]), .tx_o(tx[3]), .dbg_txcnt_o(cnt[3])
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // pb is the hand-computed parity bit, ignored for no-parity instances
    task automatic push_frame(int g, logic [7:0] d, logic pb, int gap, int cut);
        frame_t f;
        int n;
        f = '0;
        f.bits[0] = 1'b0;
        f.bits[8:1] = d;
        n = 9;
        if (par_c[g] != 0) begin
            f.bits[n] = pb;
            n++;
        end
        for (int s = 0; s < stp_c[g]; s++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nb = n;
        f.cpb = cpb_c[g];
        f.gap = gap;
        f.cut = cut;
        f.inst = 2'(g);
        if (cut == 0) exp_cnt[g] = exp_cnt[g] + 8'd1;
        f.cnt = exp_cnt[g];
        q.push_back(f);
    endtask

    task automatic send(int g, logic [7:0] d, logic pb, int cut);
        push_frame(g, d, pb, -1, cut);
        @(negedge clk);
        din[g] = d;
        en[g] = 1'b1;
        @(posedge clk);
        #1;
        en[g] = 1'b0;
        din[g] = ~d;
    endtask

    task automatic wait_done(int limit);
        int k;
        k = 0;
        while ((q.size() != 0 || mon_busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= limit) begin
            bad++;
            $display("FAIL timeout: %0d frames pending after %0d cycles", q.size(), limit);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        int idle;
        int g;
        int lim;
        frame_t f;
        idle = 0;
        forever begin
            @(negedge clk);
            if (&rdy) begin
                idle++;
            end else begin
                g = !rdy[0] ? 0 : !rdy[1] ? 1 : !rdy[2] ? 2 : 3;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: inst %0d busy, want idle", g);
                    for (int k = 0; k < 64 && !rdy[g]; k++) @(negedge clk);
                    idle = 0;
                end else begin
                    f = q.pop_front();
                    mon_busy = 1'b1;
                    chk("frame_inst", 32'(g), 32'(f.inst));
                    if (f.gap >= 0) chk("idle_gap", idle, f.gap);
                    lim = (f.cut != 0) ? f.cut : f.nb * f.cpb;
                    for (int i = 0; i < lim; i++) begin
                        if (i > 0) @(negedge clk);
                        chk($sformatf("tx_u%0d_c%0d", g, i), tx[g], f.bits[i / f.cpb]);
                        chk($sformatf("busy_u%0d_c%0d", g, i), rdy[g], 0);
                    end
                    if (f.cut == 0) begin
                        @(negedge clk);
                        chk("end_ready", rdy[g], 1);
                        chk("end_tx", tx[g], 1);
                        chk("end_txcnt", cnt[g], f.cnt);
                        idle = 1;
                    end else begin
                        idle = 0;
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        int seen;
        int k;
        logic prev;
        rst = 1'b1;
        en = '0;
        for (int g = 0; g < 4; g++) begin
            din[g] = 8'h00;
            exp_cnt[g] = 8'h00;
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_tx", tx[g], 1);
            chk("rst_ready", rdy[g], 1);
            chk("rst_txcnt", cnt[g], 0);
        end
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("quiet_lines", {tx, rdy}, 8'hFF);
            chk("quiet_cnt", {cnt[0], cnt[1], cnt[2], cnt[3]}, 0);
        end

        send(0, 8'h55, 1'b0, 0);
        wait_done(200);

        send(0, 8'h55, 1'b0, 0);
        repeat (10) @(negedge clk);
        din[0] = 8'hFF;
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        wait_done(200);

        send(1, 8'h07, 1'b1, 0);
        wait_done(200);
        send(2, 8'h07, 1'b0, 0);
        wait_done(200);

        send(0, 8'h55, 1'b0, 18);
        repeat (18) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_tx", tx[0], 1);
        chk("abort_ready", rdy[0], 1);
        chk("abort_txcnt", cnt[0], 0);
        for (int g = 0; g < 4; g++) exp_cnt[g] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(0, 8'hA5, 1'b0, 0);
        wait_done(200);

        for (int n = 0; n < 256; n++) push_frame(3, 8'h3C, 1'b0, (n == 0) ? -1 : 1, 0);
        @(negedge clk);
        din[3] = 8'h3C;
        en[3] = 1'b1;
        seen = 0;
        k = 0;
        prev = 1'b1;
        while (seen < 256 && k < 8000) begin
            @(negedge clk);
            k++;
            if (prev && !rdy[3]) seen++;
            prev = rdy[3];
        end
        en[3] = 1'b0;
        wait_done(200);
        chk("wrap_txcnt", cnt[3], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial UART transmitter that sits directly downstream of the character print chain. It accepts one byte per handshake on a ready/enable interface and shifts it out LSB-first on a single TX line as an 8-bit frame: start bit, optional parity bit, then 1 or 2 stop bits. Bit timing comes from a parameterised clock-per-bit counter. A frame counter is exposed for debug.

## Interface
- CLKS_PER_BIT, 868, system clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- CTR_WID, 10, width of the baud counter; must hold CLKS_PER_BIT-1.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  8  byte to transmit; sampled on an accepted handshake.
- en_i  input  1  transmit request; accepted only when ready_o=1.
- ready_o  output  1  high only in IDLE; the core can accept a byte.
- tx_o  output  1  serial line, registered; idles high.
- dbg_txcnt_o  output  8  count of completed frames, wraps modulo 256.

## Operation
- Reset values:
  - tx_o=1, ready_o=1, dbg_txcnt_o=0.
  - State IDLE, baud counter 0, bit index 0, shift register 0.
- States and transitions:
  - IDLE: ready_o=1 and tx_o=1. On en_i=1 at a rising edge, latch data_i into the shift register, load the parity bit, and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_o = shift register bit 0. At each bit end, shift right and increment the bit index. After bit index 7, go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: tx_o = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_o=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, go to IDLE and increment dbg_txcnt_o.
- Parity is computed over the 8 data bits only:
  - Even parity bit = XOR of data.
  - Odd parity bit = XNOR of data.
- Baud counter: counts 0..CLKS_PER_BIT-1. Each wrap to 0 marks a bit boundary. It is reset to 0 on every accept.
- en_i while ready_o=0 is ignored, with no queuing. data_i changes outside the accept edge have no effect.
- Reset asserted mid-frame aborts the frame:
  - tx_o=1 and ready_o=1 immediately, without waiting for a clock edge.
  - The partial frame is not counted.
- dbg_txcnt_o wraps 255 → 0.

## Timing
- Frame length N = 1 + 8 + (PARITY≠0) + STOP_BITS bits.
- Label the accept edge as edge 0.
- ready_o=0 and tx_o=0 (start bit) from edge 0 onward.
- Bit k occupies edges k·CLKS_PER_BIT through (k+1)·CLKS_PER_BIT−1.
- At edge N·CLKS_PER_BIT:
  - state=IDLE, ready_o=1, tx_o=1.
  - dbg_txcnt_o is updated at this same edge.
- Earliest next accept is edge N·CLKS_PER_BIT+1. Back-to-back frames therefore have exactly one extra idle-high cycle between them.
- Latency from the accept edge to the start-bit falling edge: 0 cycles after the edge (tx_o is registered at that edge).
- en_i asserted on the same edge that ready_o rises is not accepted, because ready_o was 0 before that edge.

## Test plan
- Reset check: assert rst_i for 3 cycles → tx_o=1, ready_o=1, dbg_txcnt_o=0. Then release and hold en_i=0 for 50 cycles → no change on any output.
- Basic frame: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1. Send 0x55 → tx_o sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. ready_o=0 for exactly 40 cycles. dbg_txcnt_o=1 afterwards.
- Parity: CLKS_PER_BIT=4, STOP_BITS=2, send 0x07.
  - PARITY=2 → parity bit 1.
  - PARITY=1 → parity bit 0.
  - In both cases tx_o is high for 8 cycles of stop time and ready_o is low for 48 cycles.
- Busy rejection: during the 0x55 frame, pulse en_i with data_i=0xFF in DATA state → frame bits unchanged, no second frame, dbg_txcnt_o increments by 1 only.
- Reset mid-frame: assert rst_i during data bit 3 → tx_o=1 and ready_o=1 before the next clock edge, dbg_txcnt_o=0. After release, send 0xA5 → LSB-first bits 1,0,1,0,0,1,0,1 framed correctly.
- Back-to-back and wrap: hold en_i=1 continuously with CLKS_PER_BIT=2 for 256 frames → exactly one idle-high cycle between frames, and dbg_txcnt_o returns to 0 after frame 256.
